pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/pipeline_ctrl_irq_sync.sv | 28 ++
 rtl/pipeline_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: next-PC selects, IR sources and FSM states.
package pipeline_ctrl_pkg;

    localparam logic [2:0] PCSEL_PC4   = 3'd0;
    localparam logic [2:0] PCSEL_BR    = 3'd1;
    localparam logic [2:0] PCSEL_JMP   = 3'd2;
    localparam logic [2:0] PCSEL_ILLOP = 3'd3;
    localparam logic [2:0] PCSEL_XADR  = 3'd4;
    localparam logic [2:0] PCSEL_RESET = 3'd5;

    typedef enum logic [1:0] {
        IR_SRC_DATA   = 2'd0,
        IR_SRC_NOP    = 2'd1,
        IR_SRC_EXCEPT = 2'd2
    } ir_src_e;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_XCPT  = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_irq_sync.sv
// Multi-flop synchronizer for the asynchronous irq level; STAGES cycles of latency.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic irq_s
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], irq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign irq_s = sync_q[STAGES-1];

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: next-PC select, IR bubble/exception injection and interrupt entry.
// Control outputs are combinational from state and inputs; irq latency is the synchronizer plus one cycle.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2,
    parameter int PERF_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              op_jmp,
    input  logic              op_beq,
    input  logic              op_bne,
    input  logic              zr,
    input  logic              illop,
    input  logic              irq,
    input  logic              pc_super,
    output logic [2:0]        pc_sel,
    output logic              pc_we,
    output logic [1:0]        ir_src_if,
    output logic [1:0]        ir_src_dec,
    output logic              irq_ack,
    output logic [PERF_W-1:0] bubble_cnt
);

    state_e              state_q, state_d;
    logic                irq_pend_q, irq_pend_d;
    logic [PERF_W-1:0]   bubble_cnt_q, bubble_cnt_d;
    logic                irq_s;
    logic                taken;
    logic                irq_take;
    ir_src_e             src_if, src_dec;

    irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .rst   (rst),
        .irq   (irq),
        .irq_s (irq_s)
    );

    always_comb begin
        taken    = (op_beq & zr) | (op_bne & ~zr) | op_jmp;
        irq_take = 1'b0;
        pc_sel   = PCSEL_RESET;
        pc_we    = 1'b1;
        src_if   = IR_SRC_NOP;
        src_dec  = IR_SRC_NOP;
        irq_ack  = 1'b0;
        state_d  = S_RUN;

        if (rst) begin
            state_d = S_RESET;
        end else begin
            case (state_q)
                S_RUN: begin
                    irq_take = irq_pend_q & ~pc_super & ~stall & ~taken & ~illop;
                    if (illop) begin
                        pc_sel  = PCSEL_ILLOP;
                        src_dec = IR_SRC_EXCEPT;
                        state_d = S_XCPT;
                    end else if (irq_take) begin
                        pc_sel  = PCSEL_XADR;
                        src_dec = IR_SRC_EXCEPT;
                        irq_ack = 1'b1;
                        state_d = S_XCPT;
                    end else if (taken) begin
                        pc_sel  = op_jmp ? PCSEL_JMP : PCSEL_BR;
                        src_dec = IR_SRC_DATA;
                    end else if (stall) begin
                        pc_sel  = PCSEL_PC4;
                        pc_we   = 1'b0;
                        src_if  = IR_SRC_DATA;
                    end else begin
                        pc_sel  = PCSEL_PC4;
                        src_if  = IR_SRC_DATA;
                        src_dec = IR_SRC_DATA;
                    end
                end
                S_XCPT: begin
                    pc_sel = PCSEL_PC4;
                end
                default: begin
                end
            endcase
        end

        // Pending latch holds through supervisor mode until the interrupt is actually taken.
        irq_pend_d   = irq_take ? 1'b0 : (irq_pend_q | irq_s);
        bubble_cnt_d = bubble_cnt_q;
        if (((src_if != IR_SRC_DATA) || (src_dec != IR_SRC_DATA)) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RESET;
            irq_pend_q   <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            irq_pend_q   <= irq_pend_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ir_src_if  = src_if;
    assign ir_src_dec = src_dec;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a cycle-level behavioural model of the control rules.
module tb_pipeline_ctrl;

    localparam int SYNC = 2;
    localparam int SMALL_W = 4;
    localparam int DATA = 0, NOP = 1, EXCEPT = 2;
    localparam int PH_RESET = 0, PH_RUN = 1, PH_XCPT = 2;

    logic clk = 1'b0;
    logic rst, stall, op_jmp, op_beq, op_bne, zr, illop, irq, pc_super;
    logic [2:0]  pc_sel, pc_sel_s;
    logic        pc_we, pc_we_s, irq_ack, irq_ack_s;
    logic [1:0]  ir_src_if, ir_src_dec, ir_src_if_s, ir_src_dec_s;
    logic [31:0] bubble_cnt;
    logic [SMALL_W-1:0] bubble_cnt_s;

    always #5 clk = ~clk;

    pipeline_ctrl #(.IRQ_SYNC_STAGES(SYNC), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .op_jmp(op_jmp), .op_beq(op_beq),
        .op_bne(op_bne), .zr(zr), .illop(illop), .irq(irq), .pc_super(pc_super),
        .pc_sel(pc_sel), .pc_we(pc_we), .ir_src_if(ir_src_if), .ir_src_dec(ir_src_dec),
        .irq_ack(irq_ack), .bubble_cnt(bubble_cnt)
    );

    // Narrow counter instance shares the stimulus so saturation is reached quickly.
    pipeline_ctrl #(.IRQ_SYNC_STAGES(SYNC), .PERF_W(SMALL_W)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .op_jmp(op_jmp), .op_beq(op_beq),
        .op_bne(op_bne), .zr(zr), .illop(illop), .irq(irq), .pc_super(pc_super),
        .pc_sel(pc_sel_s), .pc_we(pc_we_s), .ir_src_if(ir_src_if_s), .ir_src_dec(ir_src_dec_s),
        .irq_ack(irq_ack_s), .bubble_cnt(bubble_cnt_s)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model state
    int     m_phase;
    bit     m_pend;
    bit     m_hist[SYNC];   // irq values sampled at the last SYNC edges, [0] newest
    longint m_bub;
    int     e_sel, e_we, e_if, e_dec, e_ack;
    bit     e_take;
    int     n_ack;

    task automatic model_reset();
        m_phase = PH_RESET;
        m_pend  = 1'b0;
        m_bub   = 0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    endtask

    task automatic model_outputs();
        bit tk;
        tk = (op_beq && zr) || (op_bne && !zr) || op_jmp;
        e_take = 1'b0;
        e_ack  = 0;
        e_we   = 1;
        if (rst || m_phase == PH_RESET) begin
            e_sel = 5; e_if = NOP; e_dec = NOP;
        end else if (m_phase == PH_XCPT) begin
            e_sel = 0; e_if = NOP; e_dec = NOP;
        end else begin
            e_take = m_pend && !pc_super && !stall && !tk && !illop;
            if (illop) begin
                e_sel = 3; e_if = NOP; e_dec = EXCEPT;
            end else if (e_take) begin
                e_sel = 4; e_if = NOP; e_dec = EXCEPT; e_ack = 1;
            end else if (tk) begin
                e_sel = op_jmp ? 2 : 1; e_if = NOP; e_dec = DATA;
            end else if (stall) begin
                e_sel = 0; e_we = 0; e_if = DATA; e_dec = NOP;
            end else begin
                e_sel = 0; e_if = DATA; e_dec = DATA;
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            if (e_if != DATA || e_dec != DATA) m_bub++;
            m_pend = e_take ? 1'b0 : (m_pend | m_hist[SYNC-1]);
            for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = irq;
            m_phase = (m_phase == PH_RUN && (illop || e_take)) ? PH_XCPT : PH_RUN;
        end
    endtask

    task automatic cycle();
        longint sat;
        model_outputs();
        @(negedge clk);
        sat = (m_bub > 15) ? 15 : m_bub;
        check("pc_sel",     pc_sel,       e_sel);
        check("pc_we",      pc_we,        e_we);
        check("ir_src_if",  ir_src_if,    e_if);
        check("ir_src_dec", ir_src_dec,   e_dec);
        check("irq_ack",    irq_ack,      e_ack);
        check("bubble_cnt", bubble_cnt,   m_bub);
        check("bubble_sat", bubble_cnt_s, sat);
        if (irq_ack) n_ack++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        stall = 0; op_jmp = 0; op_beq = 0; op_bne = 0; zr = 0; illop = 0; irq = 0; pc_super = 0;
    endtask

    longint b0;
    int     a0;

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        model_reset();
        n_ack = 0;

        // Reset sequence
        cycle();
        cycle();
        rst = 1'b0;
        model_outputs();
        @(negedge clk);
        check("rst_first_sel", pc_sel, 5);
        check("rst_first_if", ir_src_if, NOP);
        @(posedge clk);
        model_update();
        #1;
        cycle();
        check("rst_next_phase_run", m_phase, PH_RUN);

        // Branch taken vs not taken
        op_beq = 1; zr = 1; b0 = bubble_cnt;
        cycle();
        check("beq_taken_bubble", bubble_cnt - b0, 1);
        zr = 0; b0 = bubble_cnt;
        cycle();
        check("beq_not_taken_bubble", bubble_cnt - b0, 0);
        idle();
        cycle();

        // Simultaneous stall, jmp, illop
        stall = 1; op_jmp = 1; illop = 1;
        cycle();
        cycle();
        idle();
        cycle();

        // Masked irq: one-cycle pulse while supervisor
        pc_super = 1; irq = 1; a0 = n_ack;
        cycle();
        irq = 0;
        for (int i = 0; i < 9; i++) cycle();
        check("masked_no_ack", n_ack - a0, 0);
        pc_super = 0;
        model_outputs();
        @(negedge clk);
        check("unmask_ack", irq_ack, 1);
        check("unmask_sel", pc_sel, 4);
        @(posedge clk);
        model_update();
        #1;
        n_ack++;
        for (int i = 0; i < 6; i++) cycle();
        check("irq_once", n_ack - a0, 1);

        // Stall for 3 cycles
        stall = 1; b0 = bubble_cnt;
        for (int i = 0; i < 3; i++) cycle();
        check("stall_bubbles", bubble_cnt - b0, 3);
        idle();
        cycle();

        // Randomized traffic including mid-exception resets
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(99) < 2);
            stall    = ($urandom_range(99) < 25);
            op_jmp   = ($urandom_range(99) < 10);
            op_beq   = ($urandom_range(99) < 12);
            op_bne   = ($urandom_range(99) < 12);
            zr       = $urandom_range(1);
            illop    = ($urandom_range(99) < 5);
            irq      = ($urandom_range(99) < 6);
            if ($urandom_range(99) < 10) pc_super = ~pc_super;
            cycle();
        end
        check("sat_final_range", (bubble_cnt_s <= 15), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
